// File: rtl/id_ex_issue.sv
// id_ex_issue: ID/EX pipeline register with hazard detection.
// Loads decoded operands/control from ID each cycle and inserts bubbles on
// taken-branch flushes and data hazards.
// Optional feature macro: ISSUE_FORWARD_EN. When it is defined, MEM/WB results
// are forwarded into ex_busA/ex_busB, and only load-use hazards stall.
module id_ex_issue #(
    parameter int XLEN = 32,
    parameter int RNUM = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_busA,
    input  logic [XLEN-1:0] id_busB,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RNUM-1:0] id_rs1,
    input  logic [RNUM-1:0] id_rs2,
    input  logic [RNUM-1:0] id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [3:0]      id_ALUctr,
    input  logic            id_ALUASrc,
    input  logic [1:0]      id_ALUBSrc,
    input  logic            id_MemRead,
    input  logic            id_RegWrite,
    input  logic            ex_flush,
    input  logic            mem_RegWrite,
    input  logic            wb_RegWrite,
    input  logic [RNUM-1:0] mem_rd,
    input  logic [RNUM-1:0] wb_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_result,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_PC,
    output logic [XLEN-1:0] ex_busA,
    output logic [XLEN-1:0] ex_busB,
    output logic [XLEN-1:0] ex_imm,
    output logic [RNUM-1:0] ex_rd,
    output logic [3:0]      ex_ALUctr,
    output logic            ex_ALUASrc,
    output logic [1:0]      ex_ALUBSrc,
    output logic            ex_MemRead,
    output logic            ex_RegWrite,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_busa_q, ex_busa_d;
    logic [XLEN-1:0] ex_busb_q, ex_busb_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [RNUM-1:0] ex_rd_q, ex_rd_d;
    logic [RNUM-1:0] ex_rs1_q, ex_rs1_d;
    logic [RNUM-1:0] ex_rs2_q, ex_rs2_d;
    logic [3:0]      ex_aluctr_q, ex_aluctr_d;
    logic            ex_alueasrc_q, ex_alueasrc_d;
    logic [1:0]      ex_alubsrc_q, ex_alubsrc_d;
    logic            ex_memread_q, ex_memread_d;
    logic            ex_regwrite_q, ex_regwrite_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic [31:0]     flush_cnt_q, flush_cnt_d;

    logic src1_act, src2_act;
    logic load_use, raw_ex, raw_mem, hazard, stall_cond, do_stall;

    // Hazard detection: ID sources against registered EX state and the MEM writer.
    always_comb begin
        src1_act = id_use_rs1 && (id_rs1 != '0);
        src2_act = id_use_rs2 && (id_rs2 != '0);
        load_use = ex_valid_q && ex_memread_q &&
                   ((src1_act && ex_rd_q == id_rs1) || (src2_act && ex_rd_q == id_rs2));
        raw_ex   = ex_valid_q && ex_regwrite_q &&
                   ((src1_act && ex_rd_q == id_rs1) || (src2_act && ex_rd_q == id_rs2));
        raw_mem  = mem_RegWrite &&
                   ((src1_act && mem_rd == id_rs1) || (src2_act && mem_rd == id_rs2));
`ifdef ISSUE_FORWARD_EN
        hazard   = load_use;
`else
        hazard   = load_use || raw_ex || raw_mem;
`endif
        stall_cond = id_valid && hazard;
        do_stall   = stall_cond && !ex_flush;
        // Reset forces the stall low even though raw_mem does not depend on flops.
        id_stall   = rst_n && do_stall;
    end

    // Next EX contents: bubble on flush or stall, otherwise take the ID fields.
    always_comb begin
        ex_valid_d    = 1'b0;
        ex_pc_d       = '0;
        ex_busa_d     = '0;
        ex_busb_d     = '0;
        ex_imm_d      = '0;
        ex_rd_d       = '0;
        ex_rs1_d      = '0;
        ex_rs2_d      = '0;
        ex_aluctr_d   = 4'b0000;
        ex_alueasrc_d = 1'b0;
        ex_alubsrc_d  = 2'b00;
        ex_memread_d  = 1'b0;
        ex_regwrite_d = 1'b0;
        stall_cnt_d   = stall_cnt_q + {31'd0, do_stall};
        flush_cnt_d   = flush_cnt_q + {31'd0, ex_flush};
        if (!ex_flush && !stall_cond) begin
            ex_valid_d    = id_valid;
            ex_pc_d       = id_pc;
            ex_busa_d     = id_busA;
            ex_busb_d     = id_busB;
            ex_imm_d      = id_imm;
            ex_rd_d       = id_rd;
            ex_rs1_d      = id_rs1;
            ex_rs2_d      = id_rs2;
            ex_aluctr_d   = id_ALUctr;
            ex_alueasrc_d = id_ALUASrc;
            ex_alubsrc_d  = id_ALUBSrc;
            ex_memread_d  = id_MemRead;
            ex_regwrite_d = id_RegWrite;
        end
    end

    // EX-stage register and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_busa_q     <= '0;
            ex_busb_q     <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_aluctr_q   <= 4'b0000;
            ex_alueasrc_q <= 1'b0;
            ex_alubsrc_q  <= 2'b00;
            ex_memread_q  <= 1'b0;
            ex_regwrite_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_busa_q     <= ex_busa_d;
            ex_busb_q     <= ex_busb_d;
            ex_imm_q      <= ex_imm_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_aluctr_q   <= ex_aluctr_d;
            ex_alueasrc_q <= ex_alueasrc_d;
            ex_alubsrc_q  <= ex_alubsrc_d;
            ex_memread_q  <= ex_memread_d;
            ex_regwrite_q <= ex_regwrite_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

`ifdef ISSUE_FORWARD_EN
    // Operand forwarding after the register: MEM beats WB beats the captured value.
    always_comb begin
        ex_busA = ex_busa_q;
        if (ex_rs1_q != '0 && mem_RegWrite && mem_rd == ex_rs1_q)
            ex_busA = mem_result;
        else if (ex_rs1_q != '0 && wb_RegWrite && wb_rd == ex_rs1_q)
            ex_busA = wb_result;
        ex_busB = ex_busb_q;
        if (ex_rs2_q != '0 && mem_RegWrite && mem_rd == ex_rs2_q)
            ex_busB = mem_result;
        else if (ex_rs2_q != '0 && wb_RegWrite && wb_rd == ex_rs2_q)
            ex_busB = wb_result;
    end
`else
    // Without forwarding the operand buses come straight from the register.
    logic unused_fwd;
    assign unused_fwd = ^{mem_result, wb_RegWrite, wb_rd, wb_result, ex_rs1_q, ex_rs2_q};
    assign ex_busA = ex_busa_q;
    assign ex_busB = ex_busb_q;
`endif

    assign ex_valid    = ex_valid_q;
    assign ex_PC       = ex_pc_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd       = ex_rd_q;
    assign ex_ALUctr   = ex_aluctr_q;
    assign ex_ALUASrc  = ex_alueasrc_q;
    assign ex_ALUBSrc  = ex_alubsrc_q;
    assign ex_MemRead  = ex_memread_q;
    assign ex_RegWrite = ex_regwrite_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Bench for id_ex_issue: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_id_ex_issue;
    localparam int XLEN = 32;
    localparam int RNUM = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_use_rs1, id_use_rs2, id_ALUASrc, id_MemRead, id_RegWrite;
    logic [XLEN-1:0] id_pc, id_busA, id_busB, id_imm;
    logic [RNUM-1:0] id_rs1, id_rs2, id_rd;
    logic [3:0] id_ALUctr;
    logic [1:0] id_ALUBSrc;
    logic ex_flush, mem_RegWrite, wb_RegWrite;
    logic [RNUM-1:0] mem_rd, wb_rd;
    logic [XLEN-1:0] mem_result, wb_result;
    logic id_stall, ex_valid, ex_ALUASrc, ex_MemRead, ex_RegWrite;
    logic [XLEN-1:0] ex_PC, ex_busA, ex_busB, ex_imm;
    logic [RNUM-1:0] ex_rd;
    logic [3:0] ex_ALUctr;
    logic [1:0] ex_ALUBSrc;
    logic [31:0] stall_cnt, flush_cnt;

    id_ex_issue #(.XLEN(XLEN), .RNUM(RNUM)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ALUctr(id_ALUctr), .id_ALUASrc(id_ALUASrc), .id_ALUBSrc(id_ALUBSrc),
        .id_MemRead(id_MemRead), .id_RegWrite(id_RegWrite), .ex_flush(ex_flush),
        .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_result(mem_result), .wb_result(wb_result),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_PC(ex_PC),
        .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_ALUctr(ex_ALUctr), .ex_ALUASrc(ex_ALUASrc), .ex_ALUBSrc(ex_ALUBSrc),
        .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the instruction sitting in EX; an empty slot is all zeros.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, busa, busb, imm;
        logic [RNUM-1:0] rd, rs1, rs2;
        logic [3:0]      ctr;
        logic            asrc;
        logic [1:0]      bsrc;
        logic            memrd, regwr;
    } ex_slot_t;

    ex_slot_t    m_ex;
    logic [31:0] m_stalls, m_flushes;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bool_src_hit(input logic use_b, input logic [RNUM-1:0] src,
                                    input logic [RNUM-1:0] dst, input logic wr);
        return use_b && src != 0 && wr && dst == src;
    endfunction

    // Would the instruction currently in ID have to wait?
    function automatic logic m_hazard();
        logic lu, rex, rmem;
        lu   = bool_src_hit(id_use_rs1, id_rs1, m_ex.rd, m_ex.valid & m_ex.memrd) ||
               bool_src_hit(id_use_rs2, id_rs2, m_ex.rd, m_ex.valid & m_ex.memrd);
        rex  = bool_src_hit(id_use_rs1, id_rs1, m_ex.rd, m_ex.valid & m_ex.regwr) ||
               bool_src_hit(id_use_rs2, id_rs2, m_ex.rd, m_ex.valid & m_ex.regwr);
        rmem = bool_src_hit(id_use_rs1, id_rs1, mem_rd, mem_RegWrite) ||
               bool_src_hit(id_use_rs2, id_rs2, mem_rd, mem_RegWrite);
`ifdef ISSUE_FORWARD_EN
        return id_valid && lu;
`else
        return id_valid && (lu || rex || rmem);
`endif
    endfunction

    // Value the ALU should see for a source index given the captured operand.
    function automatic logic [XLEN-1:0] m_operand(input logic [RNUM-1:0] src,
                                                  input logic [XLEN-1:0] captured);
`ifdef ISSUE_FORWARD_EN
        if (src != 0 && mem_RegWrite && mem_rd == src) return mem_result;
        if (src != 0 && wb_RegWrite && wb_rd == src) return wb_result;
`endif
        return captured;
    endfunction

    task automatic check_all();
        chk("id_stall",    {63'd0, id_stall}, {63'd0, rst_n && m_hazard() && !ex_flush});
        chk("ex_valid",    {63'd0, ex_valid}, {63'd0, m_ex.valid});
        chk("ex_PC",       {32'd0, ex_PC}, {32'd0, m_ex.pc});
        chk("ex_busA",     {32'd0, ex_busA}, {32'd0, m_operand(m_ex.rs1, m_ex.busa)});
        chk("ex_busB",     {32'd0, ex_busB}, {32'd0, m_operand(m_ex.rs2, m_ex.busb)});
        chk("ex_imm",      {32'd0, ex_imm}, {32'd0, m_ex.imm});
        chk("ex_ctrl",     {44'd0, ex_rd, ex_ALUctr, ex_ALUASrc, ex_ALUBSrc, ex_MemRead, ex_RegWrite},
                           {44'd0, m_ex.rd, m_ex.ctr, m_ex.asrc, m_ex.bsrc, m_ex.memrd, m_ex.regwr});
        chk("counters",    {stall_cnt, flush_cnt}, {m_stalls, m_flushes});
    endtask

    // One clock: check at the current input set, advance model and DUT.
    task automatic cycle();
        ex_slot_t nxt;
        if (!rst_n) begin
            m_ex = '0; m_stalls = 0; m_flushes = 0;
        end
        #1 check_all();
        nxt = '0;
        if (rst_n) begin
            if (ex_flush) m_flushes++;
            else if (m_hazard()) m_stalls++;
            else nxt = '{id_valid, id_pc, id_busA, id_busB, id_imm, id_rd, id_rs1, id_rs2,
                         id_ALUctr, id_ALUASrc, id_ALUBSrc, id_MemRead, id_RegWrite};
        end
        @(posedge clk);
        m_ex = nxt;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_busA = 0; id_busB = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_ALUctr = 0; id_ALUASrc = 0; id_ALUBSrc = 0; id_MemRead = 0; id_RegWrite = 0;
        ex_flush = 0; mem_RegWrite = 0; wb_RegWrite = 0; mem_rd = 0; wb_rd = 0;
        mem_result = 0; wb_result = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    task automatic set_instr(input logic [XLEN-1:0] pc, input logic [RNUM-1:0] rd,
                             input logic [RNUM-1:0] rs1, input logic u1,
                             input logic [RNUM-1:0] rs2, input logic u2,
                             input logic memrd, input logic regwr);
        id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_use_rs1 = u1;
        id_rs2 = rs2; id_use_rs2 = u2; id_MemRead = memrd; id_RegWrite = regwr;
        id_busA = pc + 32'h100; id_busB = pc + 32'h200; id_imm = pc + 32'h300;
        id_ALUctr = 4'b0110; id_ALUASrc = 1; id_ALUBSrc = 2'b01;
    endtask

    initial begin
        m_ex = '0; m_stalls = 0; m_flushes = 0;
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // Reset mid-stream
        set_instr(32'h40, 5'd9, 5'd1, 1, 5'd2, 0, 0, 1);
        id_busA = 32'h1234;
        cycle();
        chk("lit_busA_loaded", {32'd0, ex_busA}, 64'h1234);
        chk("lit_valid_loaded", {63'd0, ex_valid}, 64'd1);
        rst_n = 0;
        #1;
        chk("lit_rst_valid", {63'd0, ex_valid}, 64'd0);
        chk("lit_rst_busA", {32'd0, ex_busA}, 64'd0);
        chk("lit_rst_pc", {32'd0, ex_PC}, 64'd0);
        cycle();
        rst_n = 1;
        set_instr(32'h80, 5'd4, 5'd0, 0, 5'd0, 0, 0, 1);
        cycle();
        chk("lit_after_rst_pc", {32'd0, ex_PC}, 64'h80);

        // Load-use: one bubble
        do_reset();
        set_instr(32'h100, 5'd5, 5'd1, 0, 5'd0, 0, 1, 1);
        cycle();
        set_instr(32'h104, 5'd6, 5'd5, 1, 5'd0, 0, 0, 1);
        #1 chk("lit_lu_stall", {63'd0, id_stall}, 64'd1);
        cycle();
        chk("lit_lu_bubble", {63'd0, ex_valid}, 64'd0);
        chk("lit_lu_cnt", {32'd0, stall_cnt}, 64'd1);
        #1 chk("lit_lu_release", {63'd0, id_stall}, 64'd0);
        cycle();
        chk("lit_lu_issue_pc", {32'd0, ex_PC}, 64'h104);

        // Flush wins over load-use
        do_reset();
        set_instr(32'h200, 5'd5, 5'd0, 0, 5'd0, 0, 1, 1);
        cycle();
        set_instr(32'h204, 5'd6, 5'd5, 1, 5'd0, 0, 0, 1);
        ex_flush = 1;
        #1 chk("lit_fl_stall", {63'd0, id_stall}, 64'd0);
        cycle();
        ex_flush = 0;
        chk("lit_fl_bubble", {63'd0, ex_valid}, 64'd0);
        chk("lit_fl_cnts", {stall_cnt, flush_cnt}, {32'd0, 32'd1});

`ifdef ISSUE_FORWARD_EN
        // MEM takes priority over WB
        do_reset();
        set_instr(32'h300, 5'd8, 5'd3, 1, 5'd0, 0, 0, 1);
        id_busA = 32'h55;
        cycle();
        idle_inputs();
        mem_RegWrite = 1; mem_rd = 3; mem_result = 32'hAA;
        wb_RegWrite = 1; wb_rd = 3; wb_result = 32'hBB;
        #1 chk("lit_fwd_mem", {32'd0, ex_busA}, 64'hAA);
        mem_RegWrite = 0;
        #1 chk("lit_fwd_wb", {32'd0, ex_busA}, 64'hBB);
        cycle();
`else
        // EX RAW then MEM RAW: two bubbles
        do_reset();
        set_instr(32'h300, 5'd7, 5'd0, 0, 5'd0, 0, 0, 1);
        cycle();
        set_instr(32'h304, 5'd9, 5'd1, 0, 5'd7, 1, 0, 1);
        #1 chk("lit_raw_ex_stall", {63'd0, id_stall}, 64'd1);
        cycle();
        mem_RegWrite = 1; mem_rd = 7;
        #1 chk("lit_raw_mem_stall", {63'd0, id_stall}, 64'd1);
        cycle();
        mem_RegWrite = 0; wb_RegWrite = 1; wb_rd = 7;
        #1 chk("lit_raw_wb_free", {63'd0, id_stall}, 64'd0);
        cycle();
        chk("lit_raw_cnt", {32'd0, stall_cnt}, 64'd2);
        chk("lit_raw_issue_pc", {32'd0, ex_PC}, 64'h304);
`endif

        // x0 immunity
        do_reset();
        set_instr(32'h400, 5'd0, 5'd0, 1, 5'd0, 0, 1, 1);
        id_busA = 32'h77;
        cycle();
        set_instr(32'h404, 5'd2, 5'd0, 1, 5'd0, 1, 0, 1);
        mem_RegWrite = 1; mem_rd = 0; mem_result = 32'hAA;
        #1 chk("lit_x0_stall", {63'd0, id_stall}, 64'd0);
        chk("lit_x0_nofwd", {32'd0, ex_busA}, 64'h77);
        cycle();

        // Randomized traffic with small register indices to provoke hazards
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            id_valid     = ($urandom_range(0, 5) != 0);
            id_pc        = $urandom; id_busA = $urandom; id_busB = $urandom; id_imm = $urandom;
            id_rs1       = RNUM'($urandom_range(0, 7));
            id_rs2       = RNUM'($urandom_range(0, 7));
            id_rd        = RNUM'($urandom_range(0, 7));
            id_use_rs1   = $urandom_range(0, 1) != 0;
            id_use_rs2   = $urandom_range(0, 1) != 0;
            id_ALUctr    = 4'($urandom);
            id_ALUASrc   = $urandom_range(0, 1) != 0;
            id_ALUBSrc   = 2'($urandom);
            id_MemRead   = ($urandom_range(0, 2) == 0);
            id_RegWrite  = $urandom_range(0, 1) != 0;
            ex_flush     = ($urandom_range(0, 7) == 0);
            mem_RegWrite = $urandom_range(0, 1) != 0;
            wb_RegWrite  = $urandom_range(0, 1) != 0;
            mem_rd       = RNUM'($urandom_range(0, 7));
            wb_rd        = RNUM'($urandom_range(0, 7));
            mem_result   = $urandom;
            wb_result    = $urandom;
            cycle();
        end
        rst_n = 1;
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
